// File: rtl/serial_pkg.sv
// Shared definitions for the 8N1 serial link.
// Transmitter and receiver take their bit timing from here.
package serial_pkg;

    localparam int CLKS_PER_BIT_DEF = 5208;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is a parameter so idle-high and idle-low lines both fit.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;
    logic [1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_q <= {2{RST_VAL}};
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/decereal.sv
// 8N1 serial receiver: mid-bit sampling, LSB first, valid/ack output.
// Flags framing errors (pulse) and overruns (sticky until ack).
module decereal
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       ack,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_RLD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_RLD = TW'(HALF_BIT - 1);

    logic rxd_s;

    sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (sysclk),
        .rst_n(rst_n),
        .d    (rxd),
        .q    (rxd_s)
    );

    rx_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;
    logic          rxd_prev_q, rxd_prev_d;
    logic          tick;

    assign tick = (timer_q == '0);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        rxd_prev_d  = rxd_s;

        // Ack is applied first so a same-cycle delivery sees the slot free.
        if (ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (!rxd_s && rxd_prev_q) begin
                    state_d = START;
                    timer_d = HALF_RLD;
                end
            end
            START: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else if (!rxd_s) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    timer_d   = FULL_RLD;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    shift_d[bit_idx_q] = rxd_s;
                    timer_d            = FULL_RLD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else if (rxd_s) begin
                    state_d = IDLE;
                    if (valid_d) begin
                        overrun_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = BREAK;
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            rxd_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            rxd_prev_q  <= rxd_prev_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_decereal.sv
// Bench for decereal: directed scenarios plus random frames,
// checked against a frame-level byte/error model.
module tb_decereal;

    localparam int CPB = 16;
    localparam int HB  = 8;

    logic       sysclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       host_ack = 1'b0;
    logic       man_ack = 1'b0;
    logic       ack;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_tests = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    bit host_en = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    assign ack = host_ack | man_ack;

    decereal #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT    (HB)
    ) dut (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .ack      (ack),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) begin
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Host: acks two cycles after seeing valid, logging the byte it takes.
    initial begin
        forever begin
            @(posedge sysclk);
            #1;
            if (host_en && valid) begin
                repeat (2) @(posedge sysclk);
                #1;
                host_ack = 1'b1;
                got_q.push_back(data);
                @(posedge sysclk);
                #1;
                host_ack = 1'b0;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge sysclk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Drives a 10-bit frame (start at bit 0) for ncyc cycles; the last
    // bit is held if ncyc runs past the frame, then the line idles high.
    task automatic drive(input logic [9:0] fr, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            int k;
            k = c / CPB;
            if (k > 9) k = 9;
            rxd = fr[k];
            @(posedge sysclk);
            #1;
        end
        rxd = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        drive({1'b1, b, 1'b0}, 10 * CPB);
    endtask

    task automatic pulse_ack();
        man_ack = 1'b1;
        @(posedge sysclk);
        #1;
        man_ack = 1'b0;
    endtask

    task automatic compare_bytes(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int fe0;
        int exp_fe;
        logic [7:0] b;

        repeat (3) @(posedge sysclk);
        #1;
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(posedge sysclk);
        #1;

        // Exact delivery latency for 0xA5.
        fork
            send(8'hA5);
            begin
                repeat (154) @(posedge sysclk);
                #1;
                check("a5_early_valid", valid, 1'b0);
                @(posedge sysclk);
                #1;
                check("a5_valid", valid, 1'b1);
                check("a5_data", data, 8'hA5);
                check("a5_busy", busy, 1'b0);
            end
        join
        check("a5_ferr", frame_err, 1'b0);
        check("a5_ovr", overrun, 1'b0);
        pulse_ack();
        check("a5_acked", valid, 1'b0);
        repeat (4) @(posedge sysclk);
        #1;

        // Short low glitch is rejected at the start-bit sample.
        fe0 = fe_cnt;
        rxd = 1'b0;
        fork
            begin
                repeat (3) @(posedge sysclk);
                #1;
                rxd = 1'b1;
            end
            begin
                repeat (10) @(posedge sysclk);
                #1;
                check("glitch_busy_hi", busy, 1'b1);
                @(posedge sysclk);
                #1;
                check("glitch_busy_lo", busy, 1'b0);
            end
        join
        repeat (30) @(posedge sysclk);
        #1;
        check("glitch_valid", valid, 1'b0);
        check("glitch_ferr", fe_cnt - fe0, 0);

        // Stop bit held low for 40 cycles.
        fe0 = fe_cnt;
        fork
            drive({1'b0, 8'h3C, 1'b0}, 9 * CPB + 40);
            begin
                repeat (175) @(posedge sysclk);
                #1;
                check("brk_busy", busy, 1'b1);
                check("brk_valid", valid, 1'b0);
            end
        join
        repeat (20) @(posedge sysclk);
        #1;
        check("ferr_pulses", fe_cnt - fe0, 1);
        check("ferr_valid", valid, 1'b0);
        check("ferr_busy", busy, 1'b0);
        host_en = 1'b1;
        exp_q.push_back(8'h81);
        send(8'h81);
        repeat (20) @(posedge sysclk);
        #1;
        compare_bytes("after_brk");

        // Back-to-back frames with no idle gap.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send(8'h00);
        send(8'hFF);
        repeat (20) @(posedge sysclk);
        #1;
        compare_bytes("b2b");
        check("b2b_ovr", overrun, 1'b0);

        // Overrun: second byte dropped while the first is unread.
        host_en = 1'b0;
        send(8'h11);
        send(8'h22);
        repeat (5) @(posedge sysclk);
        #1;
        check("ovr_valid", valid, 1'b1);
        check("ovr_data", data, 8'h11);
        check("ovr_flag", overrun, 1'b1);
        pulse_ack();
        check("ovr_ack_valid", valid, 1'b0);
        check("ovr_ack_flag", overrun, 1'b0);
        repeat (4) @(posedge sysclk);
        #1;

        // Reset in the middle of data bit 4.
        drive({1'b1, 8'h5A, 1'b0}, 5 * CPB + 8);
        rxd = 1'b1;
        rst_n = 1'b0;
        #2;
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        repeat (3) @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge sysclk);
        #1;
        check("post_rst_valid", valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        host_en = 1'b1;
        exp_q.push_back(8'h5A);
        send(8'h5A);
        repeat (20) @(posedge sysclk);
        #1;
        compare_bytes("post_rst");

        // Random frames, some with a broken stop bit.
        fe0 = fe_cnt;
        exp_fe = 0;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                drive({1'b0, b, 1'b0}, 9 * CPB + $urandom_range(16, 40));
                exp_fe++;
                repeat (CPB) @(posedge sysclk);
                #1;
            end else begin
                send(b);
                exp_q.push_back(b);
            end
            repeat ($urandom_range(0, 12)) @(posedge sysclk);
            #1;
        end
        repeat (40) @(posedge sysclk);
        #1;
        compare_bytes("rand");
        check("rand_ferr", fe_cnt - fe0, exp_fe);
        check("rand_ovr", overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
